// File: rtl/spi_ram_slave_gen.sv
// spi_ram_slave_gen: single-clock SPI slave in front of a single-port RAM.
// Frame = 2 opcode bits + P payload bits (P = max(DATA_W, ADDR_W)), MSB first.
// Opcodes: 00 load wr_addr, 01 write RAM[wr_addr], 10 load rd_addr,
// 11 read RAM[rd_addr] and shift it out on MISO.
// Optional feature macro: SPI_AUTOINC_EN (address auto-increment after
// each write / read, wrapping at MEM_DEPTH-1).
// Framing: SS_n low qualifies a frame; SS_n high in any non-idle state
// aborts the frame at that edge with no RAM, address or MISO side effect.
// dbg_state exposes the FSM state for observation.
module spi_ram_slave_gen #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       MOSI,
    input  logic       SS_n,
    output logic       MISO,
    output logic       frame_done,
    output logic [2:0] dbg_state
);
    localparam int P       = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int FRAME_W = P + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0]  RX_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  TX_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(MEM_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHK_CMD = 3'd1;
    localparam logic [2:0] S_RX      = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_TX      = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               miso_q, miso_d;
    logic               frame_done_q, frame_done_d;

    logic [DATA_W-1:0]  mem [0:MEM_DEPTH-1];
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;
    logic [1:0]         opcode;
    logic [P-1:0]       payload;
    logic               wr_in_range;
    logic               rd_in_range;

    assign opcode      = rx_sr_q[FRAME_W-1 -: 2];
    assign payload     = rx_sr_q[P-1:0];
    assign wr_in_range = {1'b0, wr_addr_q} < DEPTH_X;
    assign rd_in_range = {1'b0, rd_addr_q} < DEPTH_X;
    assign mem_rdata   = mem[rd_addr_q];

    assign MISO       = miso_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

    // Next-state, shift registers, address updates and RAM write enable.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        miso_d       = 1'b0;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        if (SS_n && (state_q != S_IDLE)) begin
            // Abort: drop the frame, nothing else changes.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!SS_n) begin
                        state_d = S_CHK_CMD;
                        cnt_d   = '0;
                    end
                end
                S_CHK_CMD: begin
                    // First frame bit (opcode[1]) is captured here.
                    rx_sr_d = {rx_sr_q[FRAME_W-2:0], MOSI};
                    cnt_d   = CNT_W'(1);
                    state_d = S_RX;
                end
                S_RX: begin
                    rx_sr_d = {rx_sr_q[FRAME_W-2:0], MOSI};
                    if (cnt_q == RX_LAST) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    frame_done_d = 1'b1;
                    state_d      = S_DONE;
                    case (opcode)
                        2'b00: wr_addr_d = payload[ADDR_W-1:0];
                        2'b01: begin
                            mem_we = wr_in_range & ~rst;
`ifdef SPI_AUTOINC_EN
                            wr_addr_d = (wr_addr_q == ADDR_TOP) ? '0 : wr_addr_q + ADDR_W'(1);
`endif
                        end
                        2'b10: rd_addr_d = payload[ADDR_W-1:0];
                        2'b11: begin
                            // Out-of-range reads shift out zeros.
                            tx_sr_d = rd_in_range ? mem_rdata : '0;
                            cnt_d   = '0;
                            state_d = S_TX;
`ifdef SPI_AUTOINC_EN
                            rd_addr_d = (rd_addr_q == ADDR_TOP) ? '0 : rd_addr_q + ADDR_W'(1);
`endif
                        end
                    endcase
                end
                S_TX: begin
                    miso_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Wait for SS_n to rise (handled by the abort path).
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= payload[DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_spi_ram_slave_gen.sv
// Directed bench for spi_ram_slave_gen. Three instances:
//   dut 0: defaults (8/8/256), dut 1: MEM_DEPTH=200, dut 2: DATA_W=12, ADDR_W=6, MEM_DEPTH=64.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_spi_ram_slave_gen;
    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] mosi_v;
    logic [2:0] ss_v;
    logic [2:0] miso_v;
    logic [2:0] fd_v;
    logic [2:0] st_v [3];

    int checks;
    int errors;
    logic [15:0] exp_q[$];

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DONE = 3'd5;

    spi_ram_slave_gen u_dut0 (
        .clk(clk), .rst(rst_v[0]), .MOSI(mosi_v[0]), .SS_n(ss_v[0]),
        .MISO(miso_v[0]), .frame_done(fd_v[0]), .dbg_state(st_v[0])
    );

    spi_ram_slave_gen #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .MOSI(mosi_v[1]), .SS_n(ss_v[1]),
        .MISO(miso_v[1]), .frame_done(fd_v[1]), .dbg_state(st_v[1])
    );

    spi_ram_slave_gen #(.DATA_W(12), .ADDR_W(6), .MEM_DEPTH(64)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .MOSI(mosi_v[2]), .SS_n(ss_v[2]),
        .MISO(miso_v[2]), .frame_done(fd_v[2]), .dbg_state(st_v[2])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pw(input int d);
        return (d == 2) ? 12 : 8;
    endfunction

    function automatic int dw(input int d);
        return (d == 2) ? 12 : 8;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one complete frame on dut d; returns the bits seen on MISO for reads.
    task automatic send_frame(input int d, input logic [1:0] op, input logic [15:0] payload,
                              output logic [15:0] rdata);
        int p;
        int n;
        int fd_seen;
        logic [17:0] bits;
        p = pw(d);
        n = dw(d);
        fd_seen = 0;
        rdata = '0;
        bits = (18'(op) << p) | 18'(payload);
        @(negedge clk);
        ss_v[d] = 1'b0;
        mosi_v[d] = 1'b0;
        @(posedge clk);                          // E0
        for (int i = p + 1; i >= 0; i--) begin
            @(negedge clk);
            mosi_v[d] = bits[i];
            if (fd_v[d]) fd_seen++;
            @(posedge clk);                      // E1..E(P+2)
        end
        @(negedge clk);
        mosi_v[d] = 1'b0;
        check_val("fd_during_rx", 32'(fd_seen) + 32'(fd_v[d]), 0);
        @(posedge clk);                          // E(P+3): EXEC
        @(negedge clk);
        check_val("fd_at_exec", 32'(fd_v[d]), 1);
        if (op == 2'b11) begin
            for (int j = 0; j < n; j++) begin
                @(posedge clk);                  // E(P+4+j)
                @(negedge clk);
                if (j == 0) check_val("fd_one_cycle", 32'(fd_v[d]), 0);
                rdata = {rdata[14:0], miso_v[d]};
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("miso_zero_after", 32'(miso_v[d]), 0);
        check_val("fd_low_after", 32'(fd_v[d]), 0);
        check_val("state_done", 32'(st_v[d]), 32'(S_DONE));
        ss_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("state_idle", 32'(st_v[d]), 32'(S_IDLE));
    endtask

    task automatic wr_frame(input int d, input logic [1:0] op, input logic [15:0] payload);
        logic [15:0] dummy;
        send_frame(d, op, payload, dummy);
    endtask

    task automatic read_chk(input int d, input string tag, input logic [15:0] exp);
        logic [15:0] r;
        exp_q.push_back(exp);
        send_frame(d, 2'b11, 16'h0000, r);
        check_val(tag, 32'(r), 32'(exp_q.pop_front()));
    endtask

    initial begin
        logic [9:0] bits;
        checks = 0;
        errors = 0;
        rst_v  = 3'b111;
        ss_v   = 3'b111;
        mosi_v = 3'b000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_val("rst_miso", 32'(miso_v[d]), 0);
            check_val("rst_fd", 32'(fd_v[d]), 0);
            check_val("rst_state", 32'(st_v[d]), 32'(S_IDLE));
        end
        rst_v = 3'b000;

        // Write then read back
        wr_frame(0, 2'b00, 16'h0012);
        wr_frame(0, 2'b01, 16'h00A5);
        wr_frame(0, 2'b10, 16'h0012);
        read_chk(0, "rd_a5", 16'h00A5);

        // Abort after 5 bits of 01/0xFF
        wr_frame(0, 2'b00, 16'h0012);
        @(negedge clk);
        ss_v[0] = 1'b0;
        @(posedge clk);
        bits = {2'b01, 8'hFF};
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk);
            mosi_v[0] = bits[i];
            @(posedge clk);
        end
        @(negedge clk);
        ss_v[0] = 1'b1;
        mosi_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_state", 32'(st_v[0]), 32'(S_IDLE));
        check_val("abort_miso", 32'(miso_v[0]), 0);
        check_val("abort_fd", 32'(fd_v[0]), 0);
        wr_frame(0, 2'b10, 16'h0012);
        read_chk(0, "abort_ram_kept", 16'h00A5);

        // Reset in the middle of a read
        wr_frame(0, 2'b10, 16'h0012);
        @(negedge clk);
        ss_v[0] = 1'b0;
        @(posedge clk);
        bits = {2'b11, 8'h00};
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            mosi_v[0] = bits[i];
            @(posedge clk);
        end
        @(negedge clk);
        mosi_v[0] = 1'b0;
        @(posedge clk);                          // EXEC
        repeat (3) @(posedge clk);               // bits 7,6,5 of 0xA5
        @(negedge clk);
        check_val("miso_pre_rst", 32'(miso_v[0]), 1);
        rst_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_mid_miso", 32'(miso_v[0]), 0);
        check_val("rst_mid_state", 32'(st_v[0]), 32'(S_IDLE));
        rst_v[0] = 1'b0;
        ss_v[0] = 1'b1;
        @(posedge clk);
        wr_frame(0, 2'b01, 16'h003C);            // wr_addr back at 0
        read_chk(0, "rst_addr_zero", 16'h003C);  // rd_addr back at 0
        wr_frame(0, 2'b10, 16'h0012);
        read_chk(0, "rst_ram_kept", 16'h00A5);

        // Address auto-increment behaviour
        wr_frame(0, 2'b00, 16'h00FF);
        wr_frame(0, 2'b01, 16'h0011);
        wr_frame(0, 2'b01, 16'h0022);
        wr_frame(0, 2'b10, 16'h00FF);
`ifdef SPI_AUTOINC_EN
        read_chk(0, "inc_rd_first", 16'h0011);
        read_chk(0, "inc_rd_second", 16'h0022);
        wr_frame(0, 2'b10, 16'h0000);
        read_chk(0, "inc_ram0", 16'h0022);
`else
        read_chk(0, "inc_rd_first", 16'h0022);
        read_chk(0, "inc_rd_second", 16'h0022);
        wr_frame(0, 2'b10, 16'h0000);
        read_chk(0, "inc_ram0", 16'h003C);
`endif

        // Out-of-range protection, MEM_DEPTH=200
        wr_frame(1, 2'b00, 16'h00C7);
        wr_frame(1, 2'b01, 16'h0077);
        wr_frame(1, 2'b00, 16'h00C8);
        wr_frame(1, 2'b01, 16'h0055);
        wr_frame(1, 2'b10, 16'h00C7);
        read_chk(1, "oor_last_word", 16'h0077);
        wr_frame(1, 2'b10, 16'h00C8);
        read_chk(1, "oor_read_zero", 16'h0000);

        // Width generalisation, DATA_W=12, ADDR_W=6
        wr_frame(2, 2'b00, 16'h003F);
        wr_frame(2, 2'b01, 16'h0ABC);
        wr_frame(2, 2'b10, 16'h003F);
        read_chk(2, "wide_rd", 16'h0ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
